usb_rx_decoder: RTL and testbench
=================================

# usb_rx_decoder

Receive-side NRZI decoder for the USB full-speed link; the counterpart of the transmit encoder that drives D_plus/D_minus. Synchronizes the raw differential pins, recovers bit timing from line transitions, NRZI-decodes each bit, removes stuffed bits, and flags SE0-based end-of-packet. Output feeds the receive shift register and packet-level RX controller.

## Interface

Parameters:
- CLKS_PER_BIT, 4: clk cycles per USB bit time (48 MHz clk, 12 Mb/s).
- SAMPLE_POINT, 2: counter value at which the line is sampled; 0 < SAMPLE_POINT < CLKS_PER_BIT.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous, active-low reset.
- D_plus_in  in  1  raw D+ pin, asynchronous.
- D_minus_in  in  1  raw D- pin, asynchronous.
- rx_bit  out  1  decoded data bit; valid only while bit_valid=1.
- bit_valid  out  1  one-cycle strobe: rx_bit holds a new unstuffed data bit.
- eop  out  1  one-cycle strobe: end of packet (SE0 then J) detected.
- rx_active  out  1  high from SOP detection until eop/rx_err.
- stuff_err  out  1  one-cycle strobe: seventh consecutive 1 received.
- rx_err  out  1  one-cycle strobe: SE1 (D+=D-=1) sampled.

## Operation

- Synchronizer: two flops per pin; reset values D+ = 1, D- = 0 (J/idle).
- Edge detect: synced D+ differs from its previous registered value.
- Bit counter, width $clog2(CLKS_PER_BIT): on edge → 0; else wraps CLKS_PER_BIT-1 → 0, otherwise +1. Sample cycle = counter == SAMPLE_POINT and state != IDLE.
- Line states: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- FSM states: IDLE, ACTIVE, EOP_SE0.
  - IDLE: rx_active=0; last_line=J. Edge to K → ACTIVE (counter reset by the edge).
  - ACTIVE: each sample: J/K → decoded bit = 1 if equal to last_line, else 0; last_line updated. SE0 → EOP_SE0. SE1 → rx_err pulse, IDLE.
  - EOP_SE0: sample SE0 → stay; J → eop pulse, IDLE; K or SE1 → rx_err pulse, IDLE.
- Sync pattern KJKJKJKK therefore decodes to 0000_0001; decoder passes it through, no sync checking.
- Outputs registered. Reset values: rx_bit=1, bit_valid=0, eop=0, rx_active=0, stuff_err=0, rx_err=0; FSM IDLE; counter 0; ones count 0; last_line J.
- Reset asserted mid-packet: all state returns to reset values on that clock edge; the next packet requires a fresh J→K edge from IDLE.

## Timing

- Pin change before edge k: synced after edge k+1; counter=0 after edge k+2; sample cycle after edge k+2+SAMPLE_POINT; bit_valid/rx_bit high after edge k+3+SAMPLE_POINT (k+5 at defaults).
- bit_valid at most once per CLKS_PER_BIT cycles; each strobe lasts exactly one cycle.
- eop asserted in the same cycle rx_active falls; no bit_valid in that cycle.
- rx_active rises the cycle after the IDLE→ACTIVE edge is detected.
- Long runs without transitions (up to 7 bits): counter free-runs and wraps, one sample per bit period.

## Configuration

- USB_RX_UNSTUFF_EN defined: ones counter (3 bits) increments on each decoded 1 and clears on 0, EOP, error, or IDLE. After six consecutive 1s, the next sample is a stuff bit: no bit_valid; if it decodes 0, counter clears; if 1, stuff_err pulse, counter clears, stay ACTIVE.
- Undefined: every decoded bit produces bit_valid; stuff_err tied 0; no ones counter.

## Test plan

- Reset: hold n_rst=0 3 cycles with pins J → all outputs at reset values; release, idle J 20 cycles → no strobes, rx_active=0.
- Sync + byte: drive KJKJKJKK then NRZI of 0xA5 (LSB first), 4 clk/bit → 16 bit_valid pulses, bits 0000_0001 then 1,0,1,0,0,1,0,1; first pulse at k+5.
- EOP: after data, SE0 2 bit times then J → single eop pulse, rx_active 1→0 same cycle, FSM IDLE.
- Unstuff (macro on): data of eight 1s sent with stuff 0 after sixth → 8 bit_valid pulses all 1, stuff_err=0; resend with stuff bit omitted (seven no-transition bits) → stuff_err pulse on the seventh sample.
- Errors: SE1 during ACTIVE → rx_err pulse, rx_active=0; K after SE0 → rx_err pulse.
- Mid-packet reset: assert n_rst=0 for one cycle after 5 bits → outputs reset next edge; no eop; next packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: pin sync, bit-timing recovery, NRZI decode, SE0 end-of-packet.
// Bit unstuffing and stuff-error detection are compiled in with USB_RX_UNSTUFF_EN.
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 4,
  parameter int SAMPLE_POINT = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic D_plus_in,
  input  logic D_minus_in,
  output logic rx_bit,
  output logic bit_valid,
  output logic eop,
  output logic rx_active,
  output logic stuff_err,
  output logic rx_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_POINT);

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [1:0] {IDLE, ACTIVE, EOP_SE0} state_t;

  state_t          state, state_nxt;
  logic            dp_s1, dp_s2, dm_s1, dm_s2, dp_prev;
  logic [CW-1:0]   cnt;
  logic [1:0]      last_line, last_nxt;
  logic [1:0]      line;
  logic            edge_det, sample, dec;
  logic            bit_nxt, valid_nxt, eop_nxt, serr_nxt, rerr_nxt;
`ifdef USB_RX_UNSTUFF_EN
  logic [2:0]      ones, ones_nxt;
`endif

  assign line     = {dp_s2, dm_s2};
  assign edge_det = (dp_s2 != dp_prev);
  assign sample   = (cnt == CNT_SAMPLE) && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dp_s1     <= 1'b1;
      dp_s2     <= 1'b1;
      dm_s1     <= 1'b0;
      dm_s2     <= 1'b0;
      dp_prev   <= 1'b1;
      cnt       <= '0;
      state     <= IDLE;
      last_line <= LINE_J;
      rx_bit    <= 1'b1;
      bit_valid <= 1'b0;
      eop       <= 1'b0;
      rx_active <= 1'b0;
      stuff_err <= 1'b0;
      rx_err    <= 1'b0;
`ifdef USB_RX_UNSTUFF_EN
      ones      <= '0;
`endif
    end else begin
      dp_s1     <= D_plus_in;
      dp_s2     <= dp_s1;
      dm_s1     <= D_minus_in;
      dm_s2     <= dm_s1;
      dp_prev   <= dp_s2;
      // Any D+ transition re-centres the sample point on the new bit.
      if (edge_det || cnt == CNT_MAX) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
      state     <= state_nxt;
      last_line <= last_nxt;
      rx_bit    <= bit_nxt;
      bit_valid <= valid_nxt;
      eop       <= eop_nxt;
      rx_active <= (state_nxt != IDLE);
      stuff_err <= serr_nxt;
      rx_err    <= rerr_nxt;
`ifdef USB_RX_UNSTUFF_EN
      ones      <= ones_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_line;
    bit_nxt   = rx_bit;
    valid_nxt = 1'b0;
    eop_nxt   = 1'b0;
    serr_nxt  = 1'b0;
    rerr_nxt  = 1'b0;
    dec       = (line == last_line);
`ifdef USB_RX_UNSTUFF_EN
    ones_nxt  = ones;
`endif
    case (state)
      IDLE: begin
        last_nxt = LINE_J;
`ifdef USB_RX_UNSTUFF_EN
        ones_nxt = '0;
`endif
        if (edge_det && line == LINE_K) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (sample) begin
          case (line)
            LINE_J, LINE_K: begin
              last_nxt = line;
`ifdef USB_RX_UNSTUFF_EN
              // Bit following six 1s is a stuff bit and never reaches the shift register.
              if (ones == 3'd6) begin
                serr_nxt = dec;
                ones_nxt = '0;
              end else begin
                valid_nxt = 1'b1;
                bit_nxt   = dec;
                ones_nxt  = dec ? ones + 3'd1 : 3'd0;
              end
`else
              valid_nxt = 1'b1;
              bit_nxt   = dec;
`endif
            end
            LINE_SE0: begin
              state_nxt = EOP_SE0;
`ifdef USB_RX_UNSTUFF_EN
              ones_nxt  = '0;
`endif
            end
            default: begin
              rerr_nxt  = 1'b1;
              state_nxt = IDLE;
            end
          endcase
        end
      end
      EOP_SE0: begin
        if (sample) begin
          if (line == LINE_J) begin
            eop_nxt   = 1'b1;
            state_nxt = IDLE;
          end else if (line != LINE_SE0) begin
            rerr_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: NRZI packets, EOP, line errors, ones runs, mid-packet reset.
// Expected bit streams are hand-packed words, bit i = i-th decoded bit.
module tb_usb_rx_decoder;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00, SE1 = 2'b11;

  logic clk = 1'b0;
  logic n_rst, dp, dm;
  logic rx_bit, bit_valid, eop, rx_active, stuff_err, rx_err;

  usb_rx_decoder dut (
    .clk(clk), .n_rst(n_rst), .D_plus_in(dp), .D_minus_in(dm),
    .rx_bit(rx_bit), .bit_valid(bit_valid), .eop(eop), .rx_active(rx_active),
    .stuff_err(stuff_err), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic bits[$];
  int   vcyc[$];
  int   n_eop = 0, n_err = 0, n_stuff = 0, eop_bad = 0;
  int   eop_cyc = 0, rise_cyc = 0;
  logic prev_active = 1'b0;

  always @(negedge clk) begin
    if (bit_valid === 1'b1) begin
      bits.push_back(rx_bit);
      vcyc.push_back(cyc);
    end
    if (eop === 1'b1) begin
      n_eop   <= n_eop + 1;
      eop_cyc <= cyc;
      if (rx_active !== 1'b0 || prev_active !== 1'b1 || bit_valid !== 1'b0) eop_bad <= eop_bad + 1;
    end
    if (rx_err === 1'b1) n_err <= n_err + 1;
    if (stuff_err === 1'b1) n_stuff <= n_stuff + 1;
    if (rx_active === 1'b1 && prev_active !== 1'b1) rise_cyc <= cyc;
    prev_active <= rx_active;
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  logic [1:0] cur;
  int eop_drive = 0;

  task automatic send_line(input logic [1:0] l, input int nbits);
    {dp, dm} = l;
    repeat (4 * nbits) @(negedge clk);
  endtask

  task automatic send_data_bit(input logic b);
    if (!b) cur = (cur == J) ? K : J;
    send_line(cur, 1);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_data_bit(v[i]);
  endtask

  task automatic send_eop();
    send_line(SE0, 2);
    cur = J;
    eop_drive = cyc;
    send_line(J, 3);
  endtask

  task automatic check_pkt(input string tag, input int base, input int exp_n, input logic [31:0] exp_w);
    logic [31:0] w;
    w = '0;
    check({tag, "_count"}, bits.size() - base, exp_n);
    for (int i = 0; i < exp_n && i < 32; i++)
      if (base + i < bits.size()) w[i] = bits[base + i];
    check({tag, "_bits"}, int'(w), int'(exp_w));
  endtask

  int base, e0, r0, s0, c, gaps;

  initial begin
    n_rst = 1'b0; dp = 1'b1; dm = 1'b0; cur = J;
    repeat (3) @(negedge clk);
    check("rst_rx_bit", rx_bit, 1);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_eop", eop, 0);
    check("rst_rx_active", rx_active, 0);
    check("rst_stuff_err", stuff_err, 0);
    check("rst_rx_err", rx_err, 0);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_valid", bits.size(), 0);
    check("idle_eop", n_eop, 0);
    check("idle_err", n_err, 0);
    check("idle_active", rx_active, 0);

    // sync + 0xA5 + EOP
    base = bits.size(); e0 = n_eop; r0 = n_err; s0 = n_stuff; c = cyc;
    send_bits(32'h80, 8);
    send_bits(32'hA5, 8);
    send_eop();
    check_pkt("a5", base, 16, 32'hA580);
    check("a5_first_lat", (bits.size() > base) ? vcyc[base] - c : -1, 6);
    gaps = 0;
    for (int i = base + 1; i < bits.size(); i++) if (vcyc[i] - vcyc[i-1] != 4) gaps++;
    check("a5_spacing", gaps, 0);
    check("a5_rise_lat", rise_cyc - c, 3);
    check("a5_eop_count", n_eop - e0, 1);
    check("a5_eop_lat", eop_cyc - eop_drive, 6);
    check("a5_eop_shape", eop_bad, 0);
    check("a5_rx_err", n_err - r0, 0);
    check("a5_stuff_err", n_stuff - s0, 0);
    check("a5_active_end", rx_active, 0);

    // eight data 1s with a 0 transmitted after the sixth
    base = bits.size(); e0 = n_eop; s0 = n_stuff;
    send_bits(32'h80, 8);
    send_bits(32'h37E, 10);
    send_eop();
`ifdef USB_RX_UNSTUFF_EN
    check_pkt("ones8", base, 17, 32'h1FE80);
`else
    check_pkt("ones8", base, 18, 32'h37E80);
`endif
    check("ones8_stuff_err", n_stuff - s0, 0);
    check("ones8_eop", n_eop - e0, 1);

    // seven data 1s with no stuff bit
    base = bits.size(); e0 = n_eop; s0 = n_stuff;
    send_bits(32'h80, 8);
    send_bits(32'hFE, 8);
    send_eop();
`ifdef USB_RX_UNSTUFF_EN
    check_pkt("ones7", base, 15, 32'h7E80);
    check("ones7_stuff_err", n_stuff - s0, 1);
`else
    check_pkt("ones7", base, 16, 32'hFE80);
    check("ones7_stuff_err", n_stuff - s0, 0);
`endif
    check("ones7_eop", n_eop - e0, 1);

    // SE1 while active
    base = bits.size(); e0 = n_eop; r0 = n_err;
    send_bits(32'h80, 8);
    send_bits(32'h1, 2);
    send_line(SE1, 1);
    cur = J;
    send_line(J, 3);
    check_pkt("se1", base, 10, 32'h180);
    check("se1_rx_err", n_err - r0, 1);
    check("se1_eop", n_eop - e0, 0);
    check("se1_active", rx_active, 0);

    // K after SE0
    base = bits.size(); e0 = n_eop; r0 = n_err;
    send_bits(32'h80, 8);
    send_line(SE0, 1);
    send_line(K, 1);
    cur = J;
    send_line(J, 3);
    check("se0k_count", bits.size() - base, 8);
    check("se0k_rx_err", n_err - r0, 1);
    check("se0k_eop", n_eop - e0, 0);
    check("se0k_active", rx_active, 0);

    // reset after five bits, then a clean packet
    base = bits.size(); e0 = n_eop;
    send_bits(32'h80, 5);
    dp = 1'b1; dm = 1'b0; n_rst = 1'b0; cur = J;
    @(negedge clk);
    check("mrst_active", rx_active, 0);
    check("mrst_valid", bit_valid, 0);
    check("mrst_rx_bit", rx_bit, 1);
    n_rst = 1'b1;
    send_line(J, 5);
    check("mrst_bits", bits.size() - base, 4);
    check("mrst_eop", n_eop - e0, 0);
    base = bits.size(); e0 = n_eop;
    send_bits(32'h80, 8);
    send_bits(32'h3C, 8);
    send_eop();
    check_pkt("post_rst", base, 16, 32'h3C80);
    check("post_rst_eop", n_eop - e0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
